// File: rtl/isa_pkg.sv
// isa_pkg: instruction-set constants shared by the CPU front end.
//   OPC_W/INST_W : opcode and instruction widths (5-bit opcode + 4-bit operand)
//   OP_*         : opcode encodings, HALT_OP terminates the program
//   HALT_WORD    : word returned for unwritten / out-of-range fetches
package isa_pkg;
   localparam int OPC_W  = 5;
   localparam int INST_W = 9;

   localparam logic [OPC_W-1:0] OP_ADD         = 5'b00000;
   localparam logic [OPC_W-1:0] OP_SUB         = 5'b00001;
   localparam logic [OPC_W-1:0] OP_AND         = 5'b00010;
   localparam logic [OPC_W-1:0] OP_OR          = 5'b00011;
   localparam logic [OPC_W-1:0] OP_XOR         = 5'b00100;
   localparam logic [OPC_W-1:0] OP_SHL         = 5'b00101;
   localparam logic [OPC_W-1:0] OP_SHR         = 5'b00110;
   localparam logic [OPC_W-1:0] OP_SETI        = 5'b00111;
   localparam logic [OPC_W-1:0] OP_MOV         = 5'b01000;
   localparam logic [OPC_W-1:0] OP_LD          = 5'b01001;
   localparam logic [OPC_W-1:0] OP_ST          = 5'b01010;
   localparam logic [OPC_W-1:0] OP_MATH_TO_ADR = 5'b01011;
   localparam logic [OPC_W-1:0] OP_ZERO_REG    = 5'b01100;
   localparam logic [OPC_W-1:0] OP_JMP         = 5'b01101;
   localparam logic [OPC_W-1:0] OP_BEQ         = 5'b01110;
   localparam logic [OPC_W-1:0] OP_BNE         = 5'b01111;
   localparam logic [OPC_W-1:0] OP_NOP         = 5'b10000;
   localparam logic [OPC_W-1:0] HALT_OP        = 5'b11010;

   localparam logic [INST_W-1:0] HALT_WORD = {HALT_OP, 4'b0000};

   function automatic logic [OPC_W-1:0] get_opc(input logic [INST_W-1:0] inst);
      return inst[INST_W-1 -: OPC_W];
   endfunction
endpackage

// File: rtl/fetch_resp_fifo.sv
// fetch_resp_fifo: in-order synchronous FIFO with flush and any depth >= 2.
//   clk/rst_n          : clock, async active-low reset
//   flush              : empties the FIFO, discarding that cycle's push/pop
//   push/push_data     : write side (ignored when full and not popping)
//   pop/pop_data       : read side, pop_data is the head entry
//   empty/count        : occupancy status
module fetch_resp_fifo #(
   parameter int              WIDTH   = 8,
   parameter int              DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int             CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full, do_push, do_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage is reset so the head reads RST_VAL out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: loadable instruction memory with registered read and a
// buffered valid/ready response path.
//   clk/rst_n                    : clock, async active-low reset
//   ld_en/ld_addr/ld_data        : program load write port
//   flush                        : drop all in-flight/buffered fetches, clear halt_seen
//   req_valid/req_pc/req_ready   : fetch request handshake
//   resp_valid/resp_ready        : response handshake
//   resp_inst/resp_pc/resp_oob   : fetched word, its PC, out-of-range flag
//   halt_seen                    : sticky, a HALT instruction was consumed
module inst_mem_fetch #(
   parameter int                INST_W    = isa_pkg::INST_W,
   parameter int                PC_W      = 16,
   parameter int                DEPTH     = 256,
   parameter int                OUT_DEPTH = 4,
   parameter logic [INST_W-1:0] HALT_WORD = isa_pkg::HALT_WORD,
   localparam int               ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [INST_W-1:0] ld_data,
   input  logic              flush,
   input  logic              req_valid,
   input  logic [PC_W-1:0]   req_pc,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [INST_W-1:0] resp_inst,
   output logic [PC_W-1:0]   resp_pc,
   output logic              resp_oob,
   output logic              halt_seen
);
   localparam int FW    = 1 + PC_W + INST_W;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam logic [PC_W:0]   DEPTH_PC = (PC_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   logic [INST_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  wr_vld;

   logic              rd_v, rd_oob;
   logic [INST_W-1:0] rd_inst;
   logic [PC_W-1:0]   rd_pc;

   logic              accept, oob, push, pop, fifo_empty;
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occ;
   logic [FW-1:0]     head;

   assign idx = req_pc[ADDR_W-1:0];
   assign oob = ({1'b0, req_pc} >= DEPTH_PC);

   // Slots already committed: buffered entries plus the read in flight.
   assign occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_v};
   assign req_ready = rst_n && !ld_en && !flush && (occ < (CNT_W + 1)'(OUT_DEPTH));
   assign accept    = req_valid && req_ready;

   // Program array carries no reset; the bitmap marks written words.
   always_ff @(posedge clk) begin
      if (ld_en && ({1'b0, ld_addr} < DEPTH_A)) mem[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_vld <= '0;
      else if (ld_en && ({1'b0, ld_addr} < DEPTH_A))
         wr_vld[ld_addr] <= 1'b1;
   end

   // Read register: oob is checked first so idx never indexes past DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v    <= 1'b0;
         rd_inst <= HALT_WORD;
         rd_pc   <= '0;
         rd_oob  <= 1'b0;
      end else if (flush) begin
         rd_v <= 1'b0;
      end else begin
         rd_v <= accept;
         if (accept) begin
            rd_inst <= (oob || !wr_vld[idx]) ? HALT_WORD : mem[idx];
            rd_pc   <= req_pc;
            rd_oob  <= oob;
         end
      end
   end

   assign push = rd_v && !flush;
   assign pop  = resp_valid && resp_ready && !flush;

   fetch_resp_fifo #(
      .WIDTH   (FW),
      .DEPTH   (OUT_DEPTH),
      .RST_VAL ({1'b0, {PC_W{1'b0}}, HALT_WORD})
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data ({rd_oob, rd_pc, rd_inst}),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign resp_valid = !fifo_empty;
   assign resp_oob   = head[FW-1];
   assign resp_pc    = head[INST_W +: PC_W];
   assign resp_inst  = head[INST_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         halt_seen <= 1'b0;
      else if (flush)
         halt_seen <= 1'b0;
      else if (pop && (resp_inst[INST_W-1 -: isa_pkg::OPC_W] == isa_pkg::HALT_OP))
         halt_seen <= 1'b1;
   end
endmodule

// File: tb/tb_inst_mem_fetch.sv
module tb_inst_mem_fetch;
   import isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [8:0]  ld_data = '0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic [15:0] req_pc = '0;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [8:0]  resp_inst;
   logic [15:0] resp_pc;
   logic        resp_oob;
   logic        halt_seen;

   typedef struct {
      logic [8:0]  inst;
      logic [15:0] pc;
      logic        oob;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   inst_mem_fetch #(.DEPTH(256), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .flush(flush), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst),
      .resp_pc(resp_pc), .resp_oob(resp_oob), .halt_seen(halt_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every consumed response against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         exp_q.delete();
      end else if (resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_inst", 32'(resp_inst), 32'(e.inst));
            chk("resp_pc",   32'(resp_pc),   32'(e.pc));
            chk("resp_oob",  32'(resp_oob),  32'(e.oob));
         end
      end
   end

   // Entered just after a posedge; leaves req_valid high, just after the accepting edge.
   task automatic send(input logic [15:0] pc, input logic [8:0] inst, input logic oob);
      bit ok = 0;
      req_valid = 1'b1;
      req_pc    = pc;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (req_ready) begin
            exp_q.push_back('{inst, pc, oob});
            ok = 1;
         end
         @(posedge clk); #1;
      end
      if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load(input logic [7:0] a, input logic [8:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_inst"},  32'(resp_inst),  32'h1A0);
      chk({tag, "_resp_pc"},    32'(resp_pc),    32'd0);
      chk({tag, "_resp_oob"},   32'(resp_oob),   32'd0);
      chk({tag, "_halt_seen"},  32'(halt_seen),  32'd0);
   endtask

   initial begin
      int acc;
      // ---- reset state
      #12;
      chk_reset_vals("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk); #1;

      // ---- unwritten pc=1 -> HALT_WORD, one-cycle latency, sets halt_seen
      req_valid = 1'b1; req_pc = 16'd1;
      @(negedge clk);
      chk("t1_req_ready", 32'(req_ready), 32'd1);
      exp_q.push_back('{9'h1A0, 16'd1, 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("t1_valid_after_accept_edge", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("t1_valid_next_edge", 32'(resp_valid), 32'd1);
      @(posedge clk); #1;
      chk("t1_halt_seen", 32'(halt_seen), 32'd1);

      // ---- load program, back-to-back fetch without bubbles
      load(8'd1, {OP_SETI, 4'b0001});
      load(8'd2, {OP_MATH_TO_ADR, 4'b0000});
      load(8'd3, {OP_ZERO_REG, 4'b0001});
      fork
         begin
            send(16'd1, 9'h071, 1'b0);
            send(16'd2, 9'h0B0, 1'b0);
            send(16'd3, 9'h0C1, 1'b0);
            req_valid = 1'b0;
         end
         begin
            int k = 0;
            do begin @(negedge clk); k++; end while (!resp_valid && k < 10);
            chk("b2b_valid0", 32'(resp_valid), 32'd1);
            @(negedge clk); chk("b2b_valid1", 32'(resp_valid), 32'd1);
            @(negedge clk); chk("b2b_valid2", 32'(resp_valid), 32'd1);
         end
      join
      drain();

      // ---- backpressure: exactly OUT_DEPTH accepted
      resp_ready = 1'b0;
      acc = 0;
      req_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         req_pc = 16'(acc % 3 + 1);
         @(negedge clk);
         if (req_ready) begin
            case (acc % 3)
               0: exp_q.push_back('{9'h071, 16'd1, 1'b0});
               1: exp_q.push_back('{9'h0B0, 16'd2, 1'b0});
               default: exp_q.push_back('{9'h0C1, 16'd3, 1'b0});
            endcase
            acc++;
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("bp_accepted", 32'(acc), 32'd4);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      chk("bp_head_inst_stable", 32'(resp_inst), 32'h071);
      chk("bp_head_pc_stable", 32'(resp_pc), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      resp_ready = 1'b1;
      drain();
      send(16'd3, 9'h0C1, 1'b0);
      req_valid = 1'b0;
      drain();

      // ---- out-of-range pc
      send(16'd300, 9'h1A0, 1'b1);
      req_valid = 1'b0;
      drain();
      @(posedge clk); #1;

      // ---- flush with three entries buffered
      resp_ready = 1'b0;
      send(16'd1, 9'h071, 1'b0);
      send(16'd2, 9'h0B0, 1'b0);
      send(16'd3, 9'h0C1, 1'b0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fl_pre_halt_seen", 32'(halt_seen), 32'd1);
      flush = 1'b1; req_valid = 1'b1; req_pc = 16'd1;
      @(negedge clk);
      chk("fl_req_not_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      chk("fl_resp_valid_low", 32'(resp_valid), 32'd0);
      chk("fl_halt_cleared", 32'(halt_seen), 32'd0);
      @(negedge clk);
      chk("fl_no_late_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;

      // ---- reset mid-stream wipes the loaded program
      resp_ready = 1'b1;
      send(16'd2, 9'h0B0, 1'b0);
      send(16'd3, 9'h0C1, 1'b0);
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(16'd2, 9'h1A0, 1'b0);
      req_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
